// File: rtl/booth_prod_accum.sv
// Block accumulator for signed multiplier products: sums N products (or fewer on flush)
// into a per-step saturating accumulator and hands the block result over valid/ready.
module booth_prod_accum #(
  parameter  int PW = 8,
  parameter  int AW = 12,
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_prod,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic [CW-1:0]        out_cnt,
  output logic                 out_sat
);

  localparam logic signed [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 sat_sticky;

  logic                 accept;
  logic signed [AW:0]   s_wide;
  logic                 ovf;
  logic signed [AW-1:0] s_clamp;
  logic                 step_sat;
  logic                 last;
  logic                 close;
  logic [CW-1:0]        cnt_next;

  assign in_ready = !out_valid;
  assign accept   = in_valid && in_ready;

  // One guard bit is enough: |acc| and |in_prod| both fit in AW bits.
  assign s_wide  = {acc[AW-1], acc} + {{(AW+1-PW){in_prod[PW-1]}}, in_prod};
  assign ovf     = s_wide[AW] ^ s_wide[AW-1];
  assign s_clamp = !ovf ? s_wide[AW-1:0] : (s_wide[AW] ? SUM_MIN : SUM_MAX);

  assign step_sat = accept && ovf;
  assign last     = (cnt == CW'(N - 1));
  assign cnt_next = cnt + CW'(accept);

  // Flush only closes a non-empty block and never while a result is pending.
  assign close = (accept && last) ||
                 (flush && !out_valid && ((cnt != '0) || accept));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cnt    <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (close) begin
        out_sum    <= accept ? s_clamp : acc;
        out_cnt    <= cnt_next;
        out_sat    <= sat_sticky | step_sat;
        acc        <= '0;
        cnt        <= '0;
        sat_sticky <= 1'b0;
      end else if (accept) begin
        acc        <= s_clamp;
        cnt        <= cnt_next;
        sat_sticky <= sat_sticky | step_sat;
      end

      if (close) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
